mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum number of consecutive data grants while i_req is pending.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req  input  1  fetch-stage read request.
REQ-007 SHALL have port i_addr  input  ADDR_WIDTH  fetch address (PCF).
REQ-008 SHALL have port i_rdata  output  DATA_WIDTH  fetched instruction.
REQ-009 SHALL have port i_ready  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port d_req  input  1  memory-stage access request.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_funct3  input  3  access size/sign (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-013 SHALL have port d_addr  input  ADDR_WIDTH  data address (ALUResultM).
REQ-014 SHALL have port d_wdata  input  DATA_WIDTH  store data (WriteDataM).
REQ-015 SHALL have port d_rdata  output  DATA_WIDTH  load data.
REQ-016 SHALL have port d_ready  output  1  one-cycle data completion pulse.
REQ-017 SHALL have ports mem_req/mem_we (1), mem_funct3 (3), mem_addr (ADDR_WIDTH), mem_wdata (DATA_WIDTH), all outputs to the shared memory.
REQ-018 SHALL have ports mem_rdata  input  DATA_WIDTH  and mem_ack  input  1  (memory completion, variable latency >= 0 cycles after mem_req).
REQ-019 SHALL have ports busy  output  1  (state != IDLE) and grant_d  output  1  (current owner is the data port).

Function
REQ-020 SHALL implement states IDLE, BUSY_I, BUSY_D.
REQ-021 In IDLE, d_req=1 SHALL move to BUSY_D, unless i_req=1 and starve_cnt == STARVE_LIMIT, which SHALL move to BUSY_I.
REQ-022 In IDLE, i_req=1 with d_req=0 SHALL move to BUSY_I; no request SHALL stay in IDLE.
REQ-023 On each grant, the winner's addr/we/funct3/wdata SHALL be latched into request registers that drive the mem_* outputs; mem_we and mem_wdata SHALL be 0 for an I grant.
REQ-024 mem_req SHALL be 1 exactly while in BUSY_I or BUSY_D, and the mem_* fields SHALL stay stable until mem_ack.
REQ-025 mem_ack=1 in BUSY_x SHALL produce, in the same cycle, x_ready=1 and x_rdata=mem_rdata (d_rdata=0 for stores), then return to IDLE.
REQ-026 i_rdata/d_rdata SHALL be 0 whenever the corresponding ready is 0.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 Minimum turnaround SHALL be 2 cycles: request sampled in IDLE at cycle N, earliest ready at N+1, next grant at N+2.
REQ-029 A requester SHALL hold req high until its ready; req dropped before ready SHALL NOT abort a granted transaction.
REQ-030 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on a D grant made while i_req=1, saturate at STARVE_LIMIT, clear on any I grant, and clear in any cycle with i_req=0.
REQ-031 Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT SHALL grant D, because the memory stage holds the older instruction.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, starve_cnt=0, request registers=0, and all outputs 0.
REQ-033 Reset mid-transaction SHALL abort it: mem_req drops immediately and no ready is issued for it.
REQ-034 The first grant SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-035 A shared package (mem_arb_pkg) SHALL hold the arb_state_t enum (IDLE/BUSY_I/BUSY_D) and the funct3 size constants shared with data_mem.
REQ-036 The block SHALL be a single module with no sub-modules; the request register and starve counter are inline always_ff blocks.

Verification
REQ-037 Bench SHALL drive i_req=1, i_addr=0x40 with ack latency 0 and check mem_addr=0x40, i_ready at N+1, and i_rdata=mem_rdata=0x00A00093.
REQ-038 Bench SHALL raise i_req and d_req together (d_addr=0x1000, d_we=1, d_wdata=0xDEADBEEF, funct3=010) and check the D grant, mem_we=1, d_ready on ack, then the I grant.
REQ-039 Bench SHALL hold i_req=1 and d_req=1 for 6 transactions with STARVE_LIMIT=4 and check the grant order D,D,D,D,I,D.
REQ-040 Bench SHALL use ack latency 3 and change d_addr after the grant, then check mem_addr keeps the latched value and d_ready comes exactly 3 cycles after mem_req.
REQ-041 Bench SHALL assert rst=0 during BUSY_D and check mem_req=0 asynchronously, no d_ready, and state IDLE.
REQ-042 Bench SHALL pulse mem_ack in IDLE and check there is no ready and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter state encoding and load/store access-size codes.
// The funct3 codes are also used by data_mem.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single shared memory.
// Data wins ties, but fetch is forced through after STARVE_LIMIT back-to-back data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  grant_d
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t             r_state;
    arb_state_t             w_next;
    logic [CNT_W-1:0]       r_starve_cnt;
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   w_starved;
    logic                   w_grant_i;
    logic                   w_grant_d;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_grant_d = (r_state == IDLE) && d_req && !(i_req && w_starved);
    assign w_grant_i = (r_state == IDLE) && i_req && (!d_req || w_starved);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        busy    = 1'b0;
        grant_d = 1'b0;
        i_ready = 1'b0;
        i_rdata = '0;
        d_ready = 1'b0;
        d_rdata = '0;
        case (r_state)
            BUSY_I: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    i_ready = 1'b1;
                    i_rdata = mem_rdata;
                end
            end
            BUSY_D: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                grant_d = 1'b1;
                if (mem_ack) begin
                    d_ready = 1'b1;
                    d_rdata = r_we ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Request registers: the memory sees a stable copy of the winner until ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_grant_d) begin
            r_we     <= d_we;
            r_funct3 <= d_funct3;
            r_addr   <= d_addr;
            r_wdata  <= d_wdata;
        end else if (w_grant_i) begin
            r_we     <= 1'b0;
            r_funct3 <= F3_W;
            r_addr   <= i_addr;
            r_wdata  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (!i_req || w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    assign mem_we     = r_we;
    assign mem_funct3 = r_funct3;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory responder.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        grant_d;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 0;
    int   wait_cnt = 0;
    logic ack_pulse = 1'b0;

    mem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_funct3  (d_funct3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_funct3(mem_funct3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .grant_d   (grant_d)
    );

    always #5 clk = ~clk;

    // Memory acks once mem_req has been high for 'lat' full cycles.
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end
    assign mem_ack = ack_pulse | (mem_req && (wait_cnt == lat));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] exp_ord;
        logic       saw_ready;
        int         n;

        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_funct3 = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_ready", i_ready, 0);

        // Single fetch, zero-latency memory
        @(negedge clk);
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h40; mem_rdata = 32'h00A00093; lat = 0;
        step();
        chk("f_busy", busy, 1);
        chk("f_grant_d", grant_d, 0);
        chk("f_mem_addr", mem_addr, 32'h40);
        chk("f_mem_we", mem_we, 0);
        chk("f_i_ready", i_ready, 1);
        chk("f_i_rdata", i_rdata, 32'h00A00093);
        @(negedge clk);
        i_req = 1'b0;
        step();
        chk("f_idle", busy, 0);
        chk("f_i_ready_lo", i_ready, 0);
        chk("f_i_rdata_lo", i_rdata, 0);

        // Simultaneous requests: data store first, then fetch
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_funct3 = F3_W;
        mem_rdata = 32'h12345678;
        step();
        chk("s_grant_d", grant_d, 1);
        chk("s_mem_we", mem_we, 1);
        chk("s_mem_addr", mem_addr, 32'h1000);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_mem_funct3", mem_funct3, 3'b010);
        chk("s_d_ready", d_ready, 1);
        chk("s_d_rdata_store", d_rdata, 0);
        chk("s_i_ready", i_ready, 0);
        @(negedge clk);
        d_req = 1'b0;
        step();
        chk("s_turnaround", busy, 0);
        step();
        chk("s_i_grant", busy & ~grant_d, 1);
        chk("s_i_mem_addr", mem_addr, 32'h80);
        chk("s_i_mem_we", mem_we, 0);
        chk("s_i_mem_wdata", mem_wdata, 0);
        chk("s_i_ready", i_ready, 1);
        chk("s_i_rdata", i_rdata, 32'h12345678);
        @(negedge clk);
        i_req = 1'b0;
        step();

        // Starvation: both held, expected D,D,D,D,I,D
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        mem_rdata = 32'h55;
        exp_ord = 6'b101111;
        for (int t = 0; t < 6; t++) begin
            step();
            chk($sformatf("order%0d_busy", t), busy, 1);
            chk($sformatf("order%0d_grant_d", t), grant_d, exp_ord[t]);
            step();
            chk($sformatf("order%0d_idle", t), busy, 0);
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Latency 3 with d_addr changed after grant
        @(negedge clk);
        lat = 3; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_funct3 = F3_BU; mem_rdata = 32'hA5;
        step();
        chk("l_mem_req", mem_req, 1);
        chk("l_d_ready_early", d_ready, 0);
        @(negedge clk);
        d_addr = 32'h3000;
        n = 0;
        while (!d_ready && n < 10) begin
            step();
            n++;
            chk($sformatf("l_mem_addr%0d", n), mem_addr, 32'h2000);
        end
        chk("l_latency", n, 3);
        chk("l_funct3", mem_funct3, 3'b100);
        chk("l_d_rdata", d_rdata, 32'hA5);
        @(negedge clk);
        d_req = 1'b0;
        step();
        chk("l_idle", busy, 0);

        // Reset during BUSY_D aborts the access
        @(negedge clk);
        lat = 5; d_req = 1'b1; d_addr = 32'h3000;
        step();
        chk("r_grant_d", grant_d, 1);
        #2 rst = 1'b0;
        #1;
        chk("r_mem_req_async", mem_req, 0);
        chk("r_busy_async", busy, 0);
        chk("r_mem_addr_async", mem_addr, 0);
        saw_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            saw_ready = saw_ready | d_ready | i_ready;
        end
        chk("r_no_ready", saw_ready, 0);
        chk("r_idle", busy, 0);

        // First grant on the first edge after reset release
        @(negedge clk);
        rst = 1'b1; lat = 0; d_addr = 32'h44; mem_rdata = 32'hCAFE0001;
        step();
        chk("r_first_grant", grant_d, 1);
        chk("r_first_addr", mem_addr, 32'h44);
        chk("r_first_d_rdata", d_rdata, 32'hCAFE0001);
        @(negedge clk);
        d_req = 1'b0;
        step();

        // Stray ack in IDLE is ignored
        @(negedge clk);
        ack_pulse = 1'b1;
        #1;
        chk("a_i_ready", i_ready, 0);
        chk("a_d_ready", d_ready, 0);
        chk("a_d_rdata", d_rdata, 0);
        step();
        chk("a_busy", busy, 0);
        chk("a_mem_req", mem_req, 0);
        @(negedge clk);
        ack_pulse = 1'b0;
        step();
        chk("a_busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
